// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C write master: FSM states, quarter-bit phases
// and the R/W bit value.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ACK1,
        ST_DATA,
        ST_ACK2,
        ST_STOP
    } state_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic I2C_WRITE = 1'b0;

endpackage

// File: rtl/i2c_write_master_tick_edge.sv
// Registers a slow timebase signal and emits a one-cycle pulse on each of its
// rising edges.
module tick_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/i2c_write_master.sv
// Single-byte I2C write master: START, address+W, ACK, data, ACK, STOP,
// sequenced on a quarter-bit tick derived from the divider output.
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR      = 7'h27,
    parameter bit         USE_PORT_ADDR = 1'b0
) (
    input  logic       CLK_IN,
    input  logic       RST,
    input  logic       DIV_CLK,
    input  logic       START,
    input  logic [6:0] ADDR,
    input  logic [7:0] DATA,
    input  logic       SDA_IN,
    output logic       SCL_OE,
    output logic       SDA_OE,
    output logic       BUSY,
    output logic       DONE,
    output logic       ACK_ERR
);

    logic       tick;
    logic [6:0] addr_sel;

    state_e     state_q,   state_d;
    logic [1:0] phase_q,   phase_d;
    logic [2:0] bit_q,     bit_d;
    logic [7:0] shift_q,   shift_d;
    logic [7:0] data_q,    data_d;
    logic       scl_q,     scl_d;
    logic       sda_q,     sda_d;
    logic       busy_q,    busy_d;
    logic       done_q,    done_d;
    logic       ack_err_q, ack_err_d;

    tick_edge u_tick_edge (
        .clk_i  (CLK_IN),
        .rst_ni (RST),
        .sig_i  (DIV_CLK),
        .rise_o (tick)
    );

    assign addr_sel = USE_PORT_ADDR ? ADDR : DEV_ADDR;

    always_ff @(posedge CLK_IN or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            phase_q   <= Q0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            data_q    <= 8'd0;
            scl_q     <= 1'b0;
            sda_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        scl_d     = scl_q;
        sda_d     = sda_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;

        if (state_q == ST_IDLE) begin
            scl_d = 1'b0;
            sda_d = 1'b0;
            if (START) begin
                state_d   = ST_START;
                phase_d   = Q0;
                bit_d     = 3'd0;
                shift_d   = {addr_sel, I2C_WRITE};
                data_d    = DATA;
                busy_d    = 1'b1;
                ack_err_d = 1'b0;
            end
        end else if (tick) begin
            // Without a tick every state holds, so a frozen DIV_CLK freezes the bus.
            phase_d = phase_q + 2'd1;
            case (state_q)
                ST_START: begin
                    case (phase_q)
                        Q0: begin
                            scl_d = 1'b0;
                            sda_d = 1'b0;
                        end
                        Q1: sda_d = 1'b1;
                        Q3: begin
                            scl_d   = 1'b1;
                            state_d = ST_ADDR;
                        end
                        default: ;
                    endcase
                end
                ST_ADDR, ST_DATA: begin
                    case (phase_q)
                        Q0: sda_d = ~shift_q[7];
                        Q1: scl_d = 1'b0;
                        Q3: begin
                            scl_d   = 1'b1;
                            shift_d = {shift_q[6:0], 1'b0};
                            bit_d   = bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                state_d = (state_q == ST_ADDR) ? ST_ACK1 : ST_ACK2;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_ACK1, ST_ACK2: begin
                    case (phase_q)
                        Q0: sda_d = 1'b0;
                        Q1: scl_d = 1'b0;
                        Q2: begin
                            if (SDA_IN) begin
                                ack_err_d = 1'b1;
                            end
                        end
                        Q3: begin
                            scl_d = 1'b1;
                            // ack_err_q can only be set here by this slot's own NACK
                            if (state_q == ST_ACK1 && !ack_err_q) begin
                                state_d = ST_DATA;
                                shift_d = data_q;
                            end else begin
                                state_d = ST_STOP;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_STOP: begin
                    case (phase_q)
                        Q0: begin
                            sda_d = 1'b1;
                            scl_d = 1'b1;
                        end
                        Q1: scl_d = 1'b0;
                        Q2: sda_d = 1'b0;
                        Q3: begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = ST_IDLE;
                        end
                        default: ;
                    endcase
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign SCL_OE  = scl_q;
    assign SDA_OE  = sda_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign ACK_ERR = ack_err_q;

endmodule

// File: tb/tb_i2c_write_master.sv
// Directed + randomized bench for i2c_write_master: a wired-AND bus with a
// simple slave, checked against the expected I2C bit stream and tick counts.
module tb_i2c_write_master;

    localparam logic [6:0] DEV_A = 7'h27;
    localparam int         HALF  = 3;

    logic       clk = 1'b0;
    logic       RST;
    logic       div_clk = 1'b0;
    logic       START;
    logic [6:0] ADDR;
    logic [7:0] DATA;
    logic       SDA_IN;
    logic       SCL_OE, SDA_OE, BUSY, DONE, ACK_ERR;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // bus / monitor state
    bit          freeze  = 1'b0;
    bit          ack1_ok = 1'b1;
    bit          ack2_ok = 1'b1;
    int unsigned div_cnt = 0;
    int unsigned tick_cnt = 0;
    int unsigned falls = 0;
    int unsigned cap_n = 0;
    int unsigned start_cnt = 0;
    int unsigned stop_cnt = 0;
    int unsigned done_cnt = 0;
    int unsigned lat = 0;
    logic [31:0] cap_word = '0;
    logic        scl_prev = 1'b1, sda_prev = 1'b1, busy_prev = 1'b0;
    logic        slave_pull;

    always #5 clk = ~clk;

    // slave pulls SDA for the whole ACK slot, counted in SCL falling edges
    assign slave_pull = ((falls == 9) && ack1_ok) || ((falls == 18) && ack2_ok);
    assign SDA_IN     = ~SDA_OE & ~slave_pull;

    i2c_write_master #(
        .DEV_ADDR      (DEV_A),
        .USE_PORT_ADDR (1'b0)
    ) dut (
        .CLK_IN  (clk),
        .RST     (RST),
        .DIV_CLK (div_clk),
        .START   (START),
        .ADDR    (ADDR),
        .DATA    (DATA),
        .SDA_IN  (SDA_IN),
        .SCL_OE  (SCL_OE),
        .SDA_OE  (SDA_OE),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ACK_ERR (ACK_ERR)
    );

    always @(negedge clk) begin : monitor
        logic scl_now, sda_now, busy_rise, rise;
        scl_now   = ~SCL_OE;
        sda_now   = ~SDA_OE & ~slave_pull;
        busy_rise = BUSY & ~busy_prev;
        if (busy_rise) begin
            cap_word  <= '0;
            cap_n     <= 0;
            start_cnt <= 0;
            stop_cnt  <= 0;
            falls     <= 0;
        end else begin
            if (scl_now && !scl_prev) begin
                cap_word <= {cap_word[30:0], sda_now};
                cap_n    <= cap_n + 1;
            end
            if (!scl_now && scl_prev) falls <= falls + 1;
            if (scl_now && scl_prev && sda_prev && !sda_now) start_cnt <= start_cnt + 1;
            if (scl_now && scl_prev && !sda_prev && sda_now) stop_cnt <= stop_cnt + 1;
        end
        if (DONE) begin
            done_cnt <= done_cnt + 1;
            lat      <= tick_cnt;
        end
        scl_prev  <= scl_now;
        sda_prev  <= sda_now;
        busy_prev <= BUSY;
        rise = 1'b0;
        if (!freeze) begin
            if (div_cnt == HALF - 1) begin
                div_cnt <= 0;
                div_clk <= ~div_clk;
                rise = ~div_clk;
            end else begin
                div_cnt <= div_cnt + 1;
            end
        end
        if (busy_rise) tick_cnt <= rise ? 1 : 0;
        else if (rise) tick_cnt <= tick_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Expected SDA value at every SCL rising edge of one transaction.
    task automatic exp_bus(input logic [7:0] d, input bit a1, input bit a2,
                           output logic [31:0] w, output int unsigned n);
        logic [7:0] ab;
        ab = {DEV_A, 1'b0};
        w  = '0;
        n  = 0;
        for (int i = 7; i >= 0; i--) begin w = {w[30:0], ab[i]}; n++; end
        w = {w[30:0], ~a1}; n++;
        if (a1) begin
            for (int i = 7; i >= 0; i--) begin w = {w[30:0], d[i]}; n++; end
            w = {w[30:0], ~a2}; n++;
        end
        w = {w[30:0], 1'b0}; n++;
    endtask

    task automatic run_txn(input logic [7:0] d, input bit a1, input bit a2,
                           input bit inj, input bit frz, input bit abrt);
        int unsigned d0, en;
        bit          seen, did;
        logic [4:0]  snap;
        logic [31:0] ew;
        ack1_ok = a1;
        ack2_ok = a2;
        d0 = done_cnt;
        START = 1'b1;
        DATA  = d;
        ADDR  = 7'($urandom);
        step();
        START = 1'b0;
        ADDR  = 7'($urandom);
        DATA  = 8'($urandom);
        chk("accept_busy", BUSY, 1);
        chk("accept_ackerr_clr", ACK_ERR, 0);
        seen = 1'b0;
        did  = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (DONE) begin seen = 1'b1; break; end
            START = 1'b0;
            if (inj && !did && tick_cnt >= 10) begin
                START = 1'b1;
                DATA  = 8'h00;
                did   = 1'b1;
            end
            if (frz && !did && tick_cnt >= 12 && div_clk) begin
                did    = 1'b1;
                freeze = 1'b1;
                snap   = {SCL_OE, SDA_OE, BUSY, DONE, ACK_ERR};
                repeat (50) begin
                    step();
                    chk("freeze_hold", {SCL_OE, SDA_OE, BUSY, DONE, ACK_ERR}, snap);
                end
                freeze = 1'b0;
            end
            if (abrt && tick_cnt >= 53) begin
                chk("pre_rst_busy", BUSY, 1);
                #1 RST = 1'b0;
                #1 chk("async_rst_outputs", {SCL_OE, SDA_OE, BUSY, DONE, ACK_ERR}, 0);
                repeat (5) step();
                RST = 1'b1;
                repeat (3) step();
                chk("no_done_after_rst", done_cnt - d0, 0);
                return;
            end
        end
        chk("done_seen", seen, 1);
        if (!seen) return;
        chk("busy_low_at_done", BUSY, 0);
        step();
        chk("done_one_cycle", DONE, 0);
        exp_bus(d, a1, a2, ew, en);
        $display("txn data=%02h ack1=%0d ack2=%0d ticks=%0d bits=%0d word=%05h ack_err=%0d",
                 d, a1, a2, lat, cap_n, cap_word, ACK_ERR);
        chk("latency_ticks", lat, a1 ? 80 : 44);
        chk("bus_bit_count", cap_n, en);
        chk("bus_bits", cap_word, ew);
        chk("start_cond", start_cnt, 1);
        chk("stop_cond", stop_cnt, 1);
        chk("ack_err", ACK_ERR, (!a1 || !a2) ? 1 : 0);
        chk("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        RST   = 1'b0;
        START = 1'b0;
        ADDR  = '0;
        DATA  = '0;
        #12;
        chk("reset_outputs", {SCL_OE, SDA_OE, BUSY, DONE, ACK_ERR}, 0);
        step();
        RST = 1'b1;
        repeat (4) step();
        chk("idle_outputs", {SCL_OE, SDA_OE, BUSY, DONE, ACK_ERR}, 0);

        run_txn(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_txn(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_txn(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            run_txn(8'($urandom), ($urandom_range(3) != 0), 1'($urandom_range(1)),
                    1'b0, 1'b0, 1'b0);
        end
        run_txn(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        run_txn(8'($urandom), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        run_txn(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_txn(8'($urandom), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (5) step();
        chk("final_idle", {SCL_OE, SDA_OE, BUSY, DONE}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_write_master.md
# i2c_write_master

Single-byte I2C write master driven by the divided SCL-rate clock from the frequency divider stage. It consumes the divider's output as a quarter-bit timebase and sequences the transaction START, 7-bit address + W, ACK, data byte, ACK, STOP. It drives open-drain SCL/SDA enables toward the pad logic and reports completion and NACK status to the controlling logic.

## Interface
- `DEV_ADDR`, default 7'h27: address used when `USE_PORT_ADDR`=0.
- `USE_PORT_ADDR`, default 0: 1 = take address from `ADDR` port, 0 = from `DEV_ADDR`.
- `CLK_IN` in 1: system clock, the same clock that drives the divider.
- `RST` in 1: reset. Asynchronous, active-low.
- `DIV_CLK` in 1: divider output, at 4× the SCL bit rate. Registered in the `CLK_IN` domain.
- `START` in 1: request a transaction. Sampled only in IDLE.
- `ADDR` in 7: target address, latched when `START` is accepted.
- `DATA` in 8: byte to write, latched when `START` is accepted.
- `SDA_IN` in 1: SDA pad input, used for ACK sampling.
- `SCL_OE` out 1: 1 = pull SCL low, 0 = release.
- `SDA_OE` out 1: 1 = pull SDA low, 0 = release.
- `BUSY` out 1: transaction in progress.
- `DONE` out 1: single-cycle pulse at the end of a transaction.
- `ACK_ERR` out 1: NACK seen in the last transaction. Sticky until the next accepted `START`.

## Operation
- Tick: `tick` = `DIV_CLK` & ~`div_q`, where `div_q` is `DIV_CLK` registered. One tick per rising edge of `DIV_CLK`. Each bit spans 4 ticks, phases q0–q3.
- States: IDLE → START → ADDR → ACK1 → DATA → ACK2 → STOP → IDLE.
- IDLE: `SCL_OE`=`SDA_OE`=0. `START`=1 latches the address/data, clears `ACK_ERR`, sets `BUSY` on the next edge and resets the phase to q0.
- START condition, one tick per phase:
  - q0: release both lines.
  - q1: `SDA_OE`=1.
  - q2: hold.
  - q3: `SCL_OE`=1.
- ADDR/DATA, 8 bits each, MSB first. ADDR shifts {addr[6:0], 1'b0} (write).
  - q0: `SDA_OE`=~bit.
  - q1: `SCL_OE`=0.
  - q2: hold.
  - q3: `SCL_OE`=1.
- ACK1/ACK2 bit slot:
  - q0: `SDA_OE`=0.
  - q2: sample `SDA_IN`.
  - A sampled value of 1 sets `ACK_ERR`. After q3 go to STOP, skipping DATA if the NACK was in ACK1.
- STOP:
  - q0: `SDA_OE`=1, `SCL_OE`=1.
  - q1: `SCL_OE`=0.
  - q2: `SDA_OE`=0.
  - q3: on this tick assert `DONE` for one cycle, drop `BUSY`, return to IDLE.
- Ignored inputs:
  - `START` while `BUSY` is ignored. `ADDR`/`DATA` changes after acceptance are ignored.
  - No clock stretching: `SCL_IN` is not monitored.
  - No arbitration.

## Timing
- Reset values: `SCL_OE`=0, `SDA_OE`=0, `BUSY`=0, `DONE`=0, `ACK_ERR`=0, state IDLE, `div_q`=0.
- Reset mid-operation: bus released asynchronously. No `DONE` pulse. `ACK_ERR` cleared.
- `tick` is high one `CLK_IN` cycle after the `DIV_CLK` rising edge. All output changes are registered on that cycle's edge.
- Latency from `BUSY` rising to `DONE`:
  - Full ACKed transaction: 80 ticks (4 + 36 + 36 + 4).
  - NACK on address: 44 ticks.
- `DONE` and `BUSY` falling coincide. `START` is accepted again on the cycle after `DONE`.
- `DIV_CLK` held constant: the FSM stalls in its current phase and outputs hold.
- A bit counter of 3 bits wraps 7→0 only at the ADDR→ACK1 and DATA→ACK2 transitions.

## Structure
- Package `i2c_pkg`:
  - state encoding: IDLE, START, ADDR, ACK1, DATA, ACK2, STOP.
  - phase constants Q0..Q3.
  - `I2C_WRITE` = 1'b0.
- Sub-module `tick_edge`: `DIV_CLK` register plus rising-edge pulse, async active-low reset. It is reusable by later I2C read blocks.
- The top holds the FSM, 2-bit phase counter, 3-bit bit counter, 8-bit shift register and status flags.

## Test plan
- `USE_PORT_ADDR`=0, `DATA`=8'hA5, slave ACKs both slots → SDA bits at SCL-high equal 8'h4E then 8'hA5, `ACK_ERR`=0, `DONE` one cycle after 80 ticks.
- Slave NACKs the address (`SDA_IN`=1 at ACK1 q2) → no DATA bits driven, STOP issued, `ACK_ERR`=1, `DONE` after 44 ticks.
- ACK on address, NACK on data → `ACK_ERR`=1 after 80 ticks; the next `START` clears `ACK_ERR` in the acceptance cycle.
- `START` pulsed at tick 10 of a busy transaction with `DATA`=8'h00 → ignored; the original byte 8'hA5 is sent; exactly one `DONE`.
- `RST` low during DATA bit 3 → `SCL_OE`=`SDA_OE`=`BUSY`=0 immediately without a clock edge; no `DONE`; after release a new `START` runs a full 80-tick transaction.
- `DIV_CLK` frozen high for 50 `CLK_IN` cycles mid-ADDR → outputs unchanged throughout; the sequence resumes at the correct phase after toggling restarts.
